// File: rtl/mod_adder.sv
// Modular add/subtract over a 384-bit odd modulus, built as two passes through one shared adder.
// Optional MOD_ADDER_EARLY_DONE_EN: a subtract with no borrow finishes after a single pass.

// Registered 384-bit add/subtract; result bit 384 is carry (add) or borrow (subtract).
module add_sub_384 (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         subtract,
    input  logic [383:0] in_a,
    input  logic [383:0] in_b,
    output logic [384:0] result,
    output logic         done
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                result <= subtract ? ({1'b0, in_a} - {1'b0, in_b})
                                   : ({1'b0, in_a} + {1'b0, in_b});
            end
        end
    end
endmodule

module mod_adder (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         subtract,
    input  logic [383:0] in_a,
    input  logic [383:0] in_b,
    input  logic [383:0] in_m,
    output logic [383:0] result,
    output logic         done,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, FINISH} state_t;

    state_t       state_reg, state_next;
    logic [383:0] a_reg, b_reg, m_reg, result_reg;
    logic [384:0] r1_reg;
    logic         sub_reg, add_start_reg;

    logic         add_sub;
    logic [383:0] add_a, add_b;
    logic [384:0] add_result;
    logic         add_done;
    logic         accept;
    logic         pass2_take_t;

    assign accept = start && (state_reg == IDLE);

    add_sub_384 u_adder (
        .clk      (clk),
        .resetn   (resetn),
        .start    (add_start_reg),
        .subtract (add_sub),
        .in_a     (add_a),
        .in_b     (add_b),
        .result   (add_result),
        .done     (add_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (start) state_next = PASS1;
            PASS1: begin
                if (add_done) begin
`ifdef MOD_ADDER_EARLY_DONE_EN
                    if (sub_reg && !add_result[384]) state_next = FINISH;
                    else                             state_next = PASS2;
`else
                    state_next = PASS2;
`endif
                end
            end
            PASS2:  if (add_done) state_next = FINISH;
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // PASS1 works on the operands; PASS2 applies the opposite operation with m as the correction.
    always_comb begin
        busy    = (state_reg != IDLE);
        done    = (state_reg == FINISH);
        result  = result_reg;
        add_a   = a_reg;
        add_b   = b_reg;
        add_sub = sub_reg;
        if (state_reg == PASS2) begin
            add_a   = r1_reg[383:0];
            add_b   = m_reg;
            add_sub = !sub_reg;
        end
    end

    // Add keeps t when the sum overflowed or t did not borrow; subtract keeps t only on a borrow.
    assign pass2_take_t = sub_reg ? r1_reg[384] : (r1_reg[384] || !add_result[384]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_reg         <= '0;
            b_reg         <= '0;
            m_reg         <= '0;
            sub_reg       <= 1'b0;
            r1_reg        <= '0;
            result_reg    <= '0;
            add_start_reg <= 1'b0;
        end else begin
            add_start_reg <= accept || (state_reg == PASS1 && state_next == PASS2);
            if (accept) begin
                a_reg   <= in_a;
                b_reg   <= in_b;
                m_reg   <= in_m;
                sub_reg <= subtract;
            end
            if (state_reg == PASS1 && add_done) r1_reg <= add_result;
            if (state_reg == PASS2 && add_done)
                result_reg <= pass2_take_t ? add_result[383:0] : r1_reg[383:0];
`ifdef MOD_ADDER_EARLY_DONE_EN
            if (state_reg == PASS1 && state_next == FINISH)
                result_reg <= add_result[383:0];
`endif
        end
    end
endmodule

// File: doc/mod_adder.md
MOD_ADDER -- requirements
Module: mod_adder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and resetn as elsewhere in the codebase.
REQ-002 clk  input  1  system clock, rising-edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 subtract  input  1  0: (a+b) mod m; 1: (a-b) mod m; latched on accepted start.
REQ-006 in_a  input  384  operand a, 0 <= a < m; latched on accepted start.
REQ-007 in_b  input  384  operand b, 0 <= b < m; latched on accepted start.
REQ-008 in_m  input  384  modulus m, odd, m > 2; latched on accepted start.
REQ-009 result  output  384  reduced result, held from done until the next accepted start.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high from the cycle after an accepted start through the done cycle.

Function
REQ-012 The block SHALL instantiate exactly one existing 384-bit adder (start/subtract/in_a/in_b -> 385-bit result, done), consume its 385-bit result, and run all arithmetic through it.
REQ-013 In this document, a "pass" SHALL mean one adder start pulse followed by a wait for that adder's done pulse.
REQ-014 FSM states SHALL be IDLE, PASS1, PASS2, FINISH; start in IDLE -> PASS1; adder done in PASS1 -> PASS2 or FINISH (REQ-020); adder done in PASS2 -> FINISH; FINISH -> IDLE after one cycle.
REQ-015 The block SHALL pulse adder start in the first cycle of PASS1 and in the first cycle of PASS2.
REQ-016 PASS1 SHALL compute s = a + b (add) or d = a - b (subtract) and register the full 385-bit adder result as r1.
REQ-017 Add, PASS2: the block SHALL compute t = r1[383:0] - m; result = t[383:0] if r1[384]=1 (overflow) or t[384]=0 (no borrow), else result = r1[383:0].
REQ-018 Subtract, PASS2: the block SHALL compute t = r1[383:0] + m; result = t[383:0] if r1[384]=1 (borrow), else result = r1[383:0].
REQ-019 Result selection SHALL be registered; result and done SHALL update together in FINISH.
REQ-020 Without the REQ-026 macro, both operations SHALL always run two passes; done SHALL assert exactly one cycle after the PASS2 adder done.
REQ-021 A start asserted while busy=1, including in the done cycle, SHALL be ignored with no effect on the latched operands, the result or the FSM.
REQ-022 Operands changing after an accepted start SHALL NOT affect the result.
REQ-023 Behaviour for inputs outside the ranges in REQ-006..008 SHALL be don't-care but SHALL NOT hang the FSM.

Reset
REQ-024 On resetn=0, asynchronously: FSM -> IDLE, result = 0, done = 0, busy = 0, r1 = 0, adder start = 0.
REQ-025 Reset mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL be processed normally.

Configuration
REQ-026 Macro MOD_ADDER_EARLY_DONE_EN: when defined, a subtract with PASS1 r1[384]=0 SHALL skip PASS2 (PASS1 -> FINISH, result = r1[383:0], done one cycle after the PASS1 adder done); add is unchanged; when undefined, REQ-020 applies (constant latency).

Verification
REQ-027 m=13, a=5, b=10, add -> result=2, done exactly once, busy high throughout.
REQ-028 m=13, a=5, b=10, subtract -> result=8 (borrow path); a=10, b=5, subtract -> result=5; with MOD_ADDER_EARLY_DONE_EN, the second case's done arrives one pass earlier.
REQ-029 m=2^384-3, a=b=m-1, add -> overflow path, result=m-2; a=b=0, add -> result=0.
REQ-030 start re-pulsed with different operands during PASS1 and in the done cycle -> ignored; result from the first operands only.
REQ-031 resetn low during PASS2 -> no done pulse, result=0; a new start of m=13, a=7, b=7, add -> result=1.
